// File: rtl/pedometer_core_param.sv
// pedometer_core_param: accepts (A,B) sample pairs, keeps a tap delay line of
// A+B magnitudes, runs a serial weighted FIR (one tap per cycle) over a
// programmable weight file, and detects steps with hysteresis plus a minimum
// sample gap. Step total saturates at all-ones.
module pedometer_core_param #(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned ADDR_W  = 3,
  parameter  int unsigned CNT_W   = 16,
  parameter  int unsigned MIN_GAP = 4,
  localparam int unsigned ACC_W   = 2*DATA_W + 1 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              countSteps,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              updateWeights,
  input  logic              dualUpdateWeights,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Addr2,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic [ACC_W-1:0]  thr_hi,
  input  logic [ACC_W-1:0]  thr_lo,
  input  logic              clr_count,
  output logic [ACC_W-1:0]  filt_out,
  output logic              filt_valid,
  output logic              step_pulse,
  output logic [CNT_W-1:0]  step_count,
  output logic              wgt_err
);

  localparam int unsigned NTAP   = 2**ADDR_W;
  localparam int unsigned MAG_W  = DATA_W + 1;
  localparam int unsigned PROD_W = 2*DATA_W + 1;
  localparam logic [7:0]        GAP_MAX  = 8'(MIN_GAP);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NTAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    CMP
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ACC_W-1:0]    acc;
  logic [7:0]          gap;
  logic                armed;
  logic [DATA_W-1:0]   weight [NTAP];
  logic [MAG_W-1:0]    tap    [NTAP];

  logic [MAG_W-1:0]    mag;
  logic [PROD_W-1:0]   prod;
  logic                step_fire;
  logic                wr_req;

  // Handshake, magnitude, current tap product and the step decision.
  always_comb begin
    in_ready  = countSteps && (state == IDLE);
    mag       = {1'b0, A} + {1'b0, B};
    prod      = PROD_W'(weight[idx]) * PROD_W'(tap[idx]);
    step_fire = (state == CMP) && armed && (acc >= thr_hi) && (gap >= GAP_MAX);
    wr_req    = updateWeights || dualUpdateWeights;
  end

  // Control FSM with the tap line, accumulator and detector state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      gap        <= GAP_MAX;
      armed      <= 1'b1;
      filt_out   <= '0;
      filt_valid <= 1'b0;
      step_pulse <= 1'b0;
      for (int unsigned k = 0; k < NTAP; k++) begin
        tap[k] <= '0;
      end
    end else begin
      filt_valid <= 1'b0;
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            tap[0] <= mag;
            for (int unsigned k = 1; k < NTAP; k++) begin
              tap[k] <= tap[k-1];
            end
            acc   <= '0;
            idx   <= '0;
            gap   <= (gap >= GAP_MAX) ? GAP_MAX : gap + 8'd1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= CMP;
          end
        end
        CMP: begin
          filt_out   <= acc;
          filt_valid <= 1'b1;
          if (step_fire) begin
            step_pulse <= 1'b1;
            armed      <= 1'b0;
            gap        <= '0;
          end else if (!armed && (acc < thr_lo)) begin
            armed <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight file: writes land only in IDLE; a dual write to one address
  // leaves Data2 because its assignment is ordered last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wgt_err <= 1'b0;
      for (int unsigned k = 0; k < NTAP; k++) begin
        weight[k] <= '0;
      end
    end else begin
      wgt_err <= 1'b0;
      if (state == IDLE) begin
        if (dualUpdateWeights) begin
          weight[Addr1] <= Data1;
          weight[Addr2] <= Data2;
        end else if (updateWeights) begin
          weight[Addr1] <= Data1;
        end
      end else begin
        wgt_err <= wr_req;
      end
    end
  end

  // Saturating step counter; a clear coinciding with a step leaves one step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_count <= '0;
    end else if (clr_count) begin
      step_count <= step_fire ? CNT_W'(1) : '0;
    end else if (step_fire && (step_count != '1)) begin
      step_count <= step_count + 1'b1;
    end
  end

endmodule
